move_mask_serializer: RTL

- Takes a 32-bit board mask of destination squares, for example the output of a diagonal-shift ALU op (up-right, up-left, down-right, down-left).
- Decodes the mask back into individual (from, to) square pairs, one pair per handshake beat.
- Sits between the ALU result path and the move-list and display logic. It is the inverse of the square-to-mask shift.
- Board layout is fixed:
  - square n has row r = n[4:2] and col c = n[1:0];
  - even rows sit at board columns 2c+1;
  - odd rows sit at board columns 2c;
  - "up" means row + 1.

---
 rtl/move_mask_serializer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/move_mask_serializer.sv
// move_mask_serializer
// Turns a destination-square board mask into a stream of (from, to) square
// pairs, lowest destination first, one pair per valid/ready handshake beat.
// The source square is recovered by undoing the diagonal step (or jump) that
// produced the destination, using the fixed 32-square board layout:
// row = sq[4:2], col = sq[1:0], even rows at board column 2c+1, odd rows at 2c.

module move_mask_serializer #(
    parameter int MASK_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MASK_W-1:0] mask_in,
    input  logic [1:0]        dir,
    input  logic              jump,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_from,
    output logic [IDX_W-1:0]  out_to,
    output logic              out_last,
    output logic              done,
    output logic [5:0]        count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UR = 2'd0;
    localparam logic [1:0] DIR_UL = 2'd1;
    localparam logic [1:0] DIR_DR = 2'd2;
    localparam logic [1:0] DIR_DL = 2'd3;

    state_t             state_q;
    logic [MASK_W-1:0]  pending_q;
    logic [1:0]         dir_q;
    logic               jump_q;
    logic [5:0]         count_q;
    logic               busy_q;
    logic               out_valid_q;
    logic [IDX_W-1:0]   out_from_q;
    logic [IDX_W-1:0]   out_to_q;
    logic               out_last_q;
    logic               done_q;

    // Index of the lowest set bit; zero when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [MASK_W-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic logic is_single(input logic [MASK_W-1:0] m);
        return (m != '0) && ((m & (m - MASK_W'(1))) == '0);
    endfunction

    // Source square of a move landing on t. Row parity shifts the simple-move
    // offsets by one because odd rows sit one board column to the left.
    // Arithmetic wraps modulo 32; the mask is trusted to be legal.
    function automatic logic [IDX_W-1:0] from_square(input logic [IDX_W-1:0] t,
                                                     input logic [1:0]       d,
                                                     input logic             j);
        logic             p;
        logic [IDX_W-1:0] f;
        p = t[2];
        f = t;
        if (j) begin
            case (d)
                DIR_UR:  f = t - 5'd9;
                DIR_UL:  f = t - 5'd7;
                DIR_DR:  f = t + 5'd7;
                DIR_DL:  f = t + 5'd9;
                default: f = t;
            endcase
        end else begin
            case (d)
                DIR_UR:  f = p ? (t - 5'd5) : (t - 5'd4);
                DIR_UL:  f = p ? (t - 5'd4) : (t - 5'd3);
                DIR_DR:  f = p ? (t + 5'd3) : (t + 5'd4);
                DIR_DL:  f = p ? (t + 5'd4) : (t + 5'd5);
                default: f = t;
            endcase
        end
        return f;
    endfunction

    logic              accept_s;
    logic [MASK_W-1:0] pend_clr_s;
    logic [MASK_W-1:0] src_mask_s;
    logic [1:0]        src_dir_s;
    logic              src_jump_s;
    logic [IDX_W-1:0]  next_to_s;
    logic [IDX_W-1:0]  next_from_s;
    logic              next_last_s;

    // Next pair to present: from the incoming mask when loading, otherwise
    // from the pending mask with the just-accepted bit removed.
    always_comb begin
        accept_s   = out_valid_q & out_ready;
        pend_clr_s = pending_q & ~({{(MASK_W-1){1'b0}}, 1'b1} << out_to_q);
        if (state_q == ST_IDLE) begin
            src_mask_s = mask_in;
            src_dir_s  = dir;
            src_jump_s = jump;
        end else begin
            src_mask_s = pend_clr_s;
            src_dir_s  = dir_q;
            src_jump_s = jump_q;
        end
        next_to_s   = lowest_idx(src_mask_s);
        next_from_s = from_square(next_to_s, src_dir_s, src_jump_s);
        next_last_s = is_single(src_mask_s);
    end

    // Job sequencer with all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            dir_q       <= 2'd0;
            jump_q      <= 1'b0;
            count_q     <= 6'd0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_from_q  <= '0;
            out_to_q    <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    if (start) begin
                        pending_q <= mask_in;
                        dir_q     <= dir;
                        jump_q    <= jump;
                        count_q   <= 6'd0;
                        busy_q    <= 1'b1;
                        if (mask_in != '0) begin
                            state_q     <= ST_SCAN;
                            out_valid_q <= 1'b1;
                            out_to_q    <= next_to_s;
                            out_from_q  <= next_from_s;
                            out_last_q  <= next_last_s;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (accept_s) begin
                        pending_q <= pend_clr_s;
                        count_q   <= count_q + 6'd1;
                        if (out_last_q) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_to_q   <= next_to_s;
                            out_from_q <= next_from_s;
                            out_last_q <= next_last_s;
                        end
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pending_q   <= '0;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_from  = out_from_q;
    assign out_to    = out_to_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule
